// File: rtl/coin_pkg.sv
// Shared coin definitions for the acceptor and dispenser FSMs.
// Holds the state encoding and the coin values in nickel units.
package coin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } coin_state_e;

  localparam int NICKEL_VAL = 1;
  localparam int DIME_VAL   = 2;

endpackage

// File: rtl/coin_gap_timer.sv
// Down-counter that spaces coin pulses: loaded with GAP as a coin is emitted,
// flags expiry on the last idle cycle so the next pulse lands on schedule.
module coin_gap_timer #(
  parameter int GAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CW'(GAP);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CW'(1));

endmodule

// File: rtl/coin_change_dispenser.sv
// Greedy dime-first change dispenser emitting one-cycle D/N hopper pulses.
// Optional COIN_DISP_DIME_EMPTY_EN adds a dime_empty input forcing nickels.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
`ifdef COIN_DISP_DIME_EMPTY_EN
  input  logic             dime_empty,
`endif
  output logic             D,
  output logic             N,
  output logic             busy,
  output logic             done
);

  coin_state_e      state_q;
  logic [AMT_W-1:0] rem_q;
  logic             d_q, n_q;
  logic             gap_expired;

  logic [AMT_W-1:0] coin_src;
  logic [AMT_W-1:0] rem_d;
  logic             dime_d;
  logic             dime_ok;

`ifdef COIN_DISP_DIME_EMPTY_EN
  assign dime_ok = ~dime_empty;
`else
  assign dime_ok = 1'b1;
`endif

  // The first coin is decided straight from the request so it appears in the
  // cycle after start; later coins come from the latched remainder.
  always_comb begin
    coin_src = (state_q == ST_IDLE) ? amount : rem_q;
    dime_d   = dime_ok && (coin_src >= AMT_W'(DIME_VAL));
    rem_d    = dime_d ? coin_src - AMT_W'(DIME_VAL) : coin_src - AMT_W'(NICKEL_VAL);
  end

  generate
    if (GAP > 0) begin : g_gap
      coin_gap_timer #(.GAP(GAP)) u_gap_timer (
        .clk     (Clock),
        .rst_n   (Resetn),
        .load    ((state_q == ST_PULSE) && (rem_q != '0)),
        .expired (gap_expired)
      );
    end else begin : g_no_gap
      assign gap_expired = 1'b1;
    end
  endgenerate

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      d_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      d_q <= 1'b0;
      n_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (amount != '0) begin
              state_q <= ST_PULSE;
              rem_q   <= rem_d;
              d_q     <= dime_d;
              n_q     <= ~dime_d;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_PULSE: begin
          if (rem_q == '0) begin
            state_q <= ST_DONE;
          end else if (GAP > 0) begin
            state_q <= ST_GAP;
          end else begin
            rem_q <= rem_d;
            d_q   <= dime_d;
            n_q   <= ~dime_d;
          end
        end
        ST_GAP: begin
          if (gap_expired) begin
            state_q <= ST_PULSE;
            rem_q   <= rem_d;
            d_q     <= dime_d;
            n_q     <= ~dime_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign D    = d_q;
  assign N    = n_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Randomized self-checking bench: two dispensers (GAP=1 and GAP=0) against
// a cycle-schedule reference derived from the coin count of each request.
module tb_coin_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amount = 4'd0;
  logic       dime_empty = 1'b0;

  logic d1, n1, b1, dn1;
  logic d0, n0, b0, dn0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  coin_change_dispenser #(.AMT_W(4), .GAP(1)) u_dut_g1 (
    .Clock      (clk),
    .Resetn     (rst_n),
    .start      (start),
    .amount     (amount),
`ifdef COIN_DISP_DIME_EMPTY_EN
    .dime_empty (dime_empty),
`endif
    .D          (d1),
    .N          (n1),
    .busy       (b1),
    .done       (dn1)
  );

  coin_change_dispenser #(.AMT_W(4), .GAP(0)) u_dut_g0 (
    .Clock      (clk),
    .Resetn     (rst_n),
    .start      (start),
    .amount     (amount),
`ifdef COIN_DISP_DIME_EMPTY_EN
    .dime_empty (dime_empty),
`endif
    .D          (d0),
    .N          (n0),
    .busy       (b0),
    .done       (dn0)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_coins(input int a, input bit de);
    return de ? a : (a / 2 + a % 2);
  endfunction

  function automatic int latency(input int g, input int a, input bit de);
    int c;
    c = n_coins(a, de);
    return (c == 0) ? 1 : c * (g + 1) - g + 1;
  endfunction

  // sel: 0=D 1=N 2=busy 3=done, for cycle t counted from the accepting edge
  function automatic int exp_val(input int g, input int a, input bit de,
                                 input int t, input int sel);
    int c, l, k;
    bit is_slot, is_dime;
    c = n_coins(a, de);
    l = latency(g, a, de);
    k = (t - 1) / (g + 1);
    is_slot = (t >= 1) && ((t - 1) % (g + 1) == 0) && (k < c);
    is_dime = !de && (k < a / 2);
    case (sel)
      0: return (is_slot && is_dime) ? 1 : 0;
      1: return (is_slot && !is_dime) ? 1 : 0;
      2: return (t >= 1 && t <= l) ? 1 : 0;
      default: return (t == l) ? 1 : 0;
    endcase
  endfunction

  task automatic check_cycle(input int t, input int a, input bit de);
    chk($sformatf("g1_D a=%0d t=%0d", a, t),    d1,  exp_val(1, a, de, t, 0));
    chk($sformatf("g1_N a=%0d t=%0d", a, t),    n1,  exp_val(1, a, de, t, 1));
    chk($sformatf("g1_busy a=%0d t=%0d", a, t), b1,  exp_val(1, a, de, t, 2));
    chk($sformatf("g1_done a=%0d t=%0d", a, t), dn1, exp_val(1, a, de, t, 3));
    chk($sformatf("g0_D a=%0d t=%0d", a, t),    d0,  exp_val(0, a, de, t, 0));
    chk($sformatf("g0_N a=%0d t=%0d", a, t),    n0,  exp_val(0, a, de, t, 1));
    chk($sformatf("g0_busy a=%0d t=%0d", a, t), b0,  exp_val(0, a, de, t, 2));
    chk($sformatf("g0_done a=%0d t=%0d", a, t), dn0, exp_val(0, a, de, t, 3));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_g1_D"}, d1, 0);
    chk({tag, "_g1_N"}, n1, 0);
    chk({tag, "_g1_busy"}, b1, 0);
    chk({tag, "_g1_done"}, dn1, 0);
    chk({tag, "_g0_D"}, d0, 0);
    chk({tag, "_g0_N"}, n0, 0);
    chk({tag, "_g0_busy"}, b0, 0);
    chk({tag, "_g0_done"}, dn0, 0);
  endtask

  // stray_t: cycle in which an ignored start is driven (0 = none)
  task automatic run_txn(input int a, input bit de, input int stray_t, input int stray_a);
    int lmax;
    @(negedge clk);
    amount     = 4'(a);
    dime_empty = de;
    start      = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    amount = 4'($urandom_range(0, 15));
    lmax = latency(1, a, de);
    for (int t = 1; t <= lmax + 1; t++) begin
      start = 1'b0;
      check_cycle(t, a, de);
      if (t == stray_t) begin
        start  = 1'b1;
        amount = 4'(stray_a);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    bit de;
    int a, st;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("post_reset");

    run_txn(3, 1'b0, 0, 0);
    run_txn(0, 1'b0, 0, 0);
    run_txn(15, 1'b0, 0, 0);
`ifdef COIN_DISP_DIME_EMPTY_EN
    run_txn(4, 1'b1, 0, 0);
`else
    run_txn(4, 1'b0, 0, 0);
`endif
    run_txn(3, 1'b0, 2, 5);

    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 15);
`ifdef COIN_DISP_DIME_EMPTY_EN
      de = ($urandom_range(0, 3) == 0);
`else
      de = 1'b0;
`endif
      st = $urandom_range(0, latency(0, a, de));
      run_txn(a, de, st, $urandom_range(0, 15));
    end

    // Asynchronous reset in the middle of an amount=6 payout
    @(negedge clk);
    amount     = 4'd6;
    dime_empty = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_cycle(1, 6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check_all_zero($sformatf("after_reset%0d", t));
    end

    run_txn(5, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/coin_change_dispenser.md
# coin_change_dispenser

- Transmit-side counterpart of the nickel/dime coin-acceptor FSM.
- Given a requested amount in nickel units, emits one-cycle `D` (dime) and `N` (nickel) pulses to the coin hopper until the amount is paid out.
- Uses greedy dime-first selection, with a configurable spacing between coins.
- Sits between the vending controller (change/refund request) and the coin hopper drivers.

## Interface

**Parameters**
- `AMT_W`, default 4: width of `amount`, in nickel units. The default covers 0..15, i.e. 0..75 cents.
- `GAP`, default 1: number of idle cycles inserted between consecutive coin pulses. 0 means back-to-back pulses.

**Ports**
- Clock, reset and all other timing behaviour are fixed as follows. One clock; reset is asynchronous and active-low.
- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `amount`  in  AMT_W  payout amount in nickels; sampled with `start`.
- `dime_empty`  in  1  hopper has no dimes. Present only with `COIN_DISP_DIME_EMPTY_EN`.
- `D`  out  1  dime pulse; registered, high for exactly one cycle per dime.
- `N`  out  1  nickel pulse; registered, high for exactly one cycle per nickel.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation

**States:** IDLE, PULSE, GAP, DONE.
- In IDLE with `start`=1:
  - `amount`≠0 → latch `remaining`=`amount`; go to PULSE.
  - `amount`=0 → go to DONE (no coins).
- Entering PULSE, the coin decision is made on the registered `remaining`:
  - `remaining`≥2 and dimes allowed → `D`=1, `remaining`−=2.
  - Otherwise → `N`=1, `remaining`−=1.
- After PULSE:
  - `remaining`=0 → DONE.
  - Else, if GAP>0 → GAP state for GAP cycles, then PULSE.
  - Else (GAP=0) → PULSE again.
- DONE lasts exactly one cycle, then IDLE.
- `D` and `N` are never high together. Both are low in GAP, DONE and IDLE.
- `start` is ignored while `busy`. It is not queued.
- `remaining` is AMT_W bits and is never decremented below 0. The dime branch requires `remaining`≥2.
- Coin count for amount A with dimes allowed: ⌊A/2⌋ dimes, then A mod 2 nickels. Dimes always precede the nickel.
- **Reset, at any time including mid-payout:** state=IDLE, `remaining`=0, gap counter=0. `D`=`N`=`busy`=`done`=0. A partially paid amount is discarded, not resumed.

## Timing

- Cycle 0 = the edge at which `start` is sampled high.
- **First coin:** visible in cycle 1.
- **Coin pulse k:** starts at cycle 1+k·(GAP+1).
- **Completion:** `done` is high in the cycle after the last coin.
- **Total latency:** C·(GAP+1)−GAP+1 cycles from start to `done`, for C coins.
- **amount=0:** `done` in cycle 1, `busy`=1 in cycle 1 only.
- **`busy`:** high from cycle 1 through the `done` cycle inclusive. A new `start` is accepted at the first edge where the state is IDLE, i.e. the cycle after `done`.

## Configuration

- **`COIN_DISP_DIME_EMPTY_EN` defined:**
  - The `dime_empty` port exists.
  - `dime_empty` is sampled at each PULSE decision. When high, a nickel is emitted even if `remaining`≥2.
  - A dime/nickel mix is allowed mid-payout.
- **Not defined:** the port is absent and dimes are always allowed.

## Structure

- **Shared package `coin_pkg`:**
  - State enum (IDLE, PULSE, GAP, DONE).
  - Coin-value constants NICKEL_VAL=1 and DIME_VAL=2, in nickel units.
  - Shared with the acceptor FSM.
- **Sub-module `coin_gap_timer`:** a down-counter loaded with GAP on each coin pulse that flags expiry. It is bypassed when GAP=0.

## Test plan

- **Basic payout:** GAP=1, `amount`=3 → `D` in cycle 1, idle in cycle 2, `N` in cycle 3, `done` in cycle 4, `busy` in cycles 1–4.
- **Zero amount:** `amount`=0 → `done` in cycle 1; `D`=`N`=0 throughout.
- **Maximum amount:** GAP=0, `amount`=15 → `D` in cycles 1–7, `N` in cycle 8, `done` in cycle 9.
- **Dimes empty:** `COIN_DISP_DIME_EMPTY_EN` defined, `dime_empty`=1, `amount`=4 → four `N` pulses, zero `D` pulses, then `done`.
- **Busy ignores start:** `start` with `amount`=5 pulsed in cycle 2 of an `amount`=3 payout → ignored; exactly one `done`, 2 coins total.
- **Reset mid-payout:** `Resetn` low after the first `D` of `amount`=6 → all outputs 0 immediately. After release, no further pulses until a new `start`.
